// File: rtl/dmem_responder.sv
// dmem_responder
//
// Memory-side responder for the CPU data port. Reads see a fixed number of
// wait states, during which the CPU is held by StallM. Writes are posted
// into a small FIFO write buffer. The buffer drains into a single-port RAM
// during cycles that use neither the RAM nor the buffer, and buffered data
// is forwarded to later reads of the same word.
//
// Ports:
//   CLK, Reset       clock, synchronous active-high reset
//   MemReqM          request valid (held stable by the CPU while StallM=1)
//   MemWriteM        1 = write, 0 = read
//   ALUOutM          word address (low AW bits index the RAM, upper bits must be 0)
//   WriteDataM       write data
//   ReadDataM        registered read data, holds until the next response
//   StallM           combinational hold request to the CPU memory stage
//   RdValidM         one-cycle pulse, ReadDataM valid
//   AddrErrM         one-cycle pulse on an out-of-range access
//   WbCount          write-buffer occupancy
//   dbg_state        read FSM state (0 idle, 1 wait, 2 resp)
//
// Handshake: MemReqM is valid, !StallM is ready. A write transfers in the
// cycle where MemReqM=1 and StallM=0. A read is taken in IDLE, keeps StallM
// high through its wait states, and completes in the RdValidM cycle, where
// the still-visible request is consumed rather than taken again.

module dmem_responder #(
  parameter int SIZE     = 48,
  parameter int DEPTH    = 256,
  parameter int LATENCY  = 2,
  parameter int WB_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          Reset,
  input  logic                          MemReqM,
  input  logic                          MemWriteM,
  input  logic [SIZE-1:0]               ALUOutM,
  input  logic [SIZE-1:0]               WriteDataM,
  output logic [SIZE-1:0]               ReadDataM,
  output logic                          StallM,
  output logic                          RdValidM,
  output logic                          AddrErrM,
  output logic [$clog2(WB_DEPTH+1)-1:0] WbCount,
  output logic [1:0]                    dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WB_DEPTH + 1);
  localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Read FSM
  logic [1:0]      state_q, state_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] addr_q, addr_d;
  logic [SIZE-1:0] read_data_q, read_data_d;
  logic            addr_err_q, addr_err_d;

  // Write buffer
  logic [AW-1:0]   wb_idx_q  [WB_DEPTH];
  logic [AW-1:0]   wb_idx_d  [WB_DEPTH];
  logic [SIZE-1:0] wb_data_q [WB_DEPTH];
  logic [SIZE-1:0] wb_data_d [WB_DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic [SIZE-1:0] ram [DEPTH];

  // Decode
  logic            rd_req, wr_req, in_idle;
  logic            wb_full, wr_oor, wr_acc, enq, drain;
  logic            lookup;
  logic [SIZE-1:0] lookup_addr;
  logic [AW-1:0]   lookup_idx;
  logic            lookup_oor;
  logic [SIZE-1:0] ram_rdata;
  logic            fwd_hit;
  logic [SIZE-1:0] fwd_data;
  logic [PW-1:0]   fwd_pos;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(WB_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_req  = MemReqM && !MemWriteM;
    wr_req  = MemReqM && MemWriteM;
    in_idle = (state_q == S_IDLE);
    wb_full = (count_q == CW'(WB_DEPTH));
    wr_oor  = |ALUOutM[SIZE-1:AW];
    wr_acc  = in_idle && wr_req && !wb_full;
    enq     = wr_acc && !wr_oor;

    // The lookup cycle is the one right before RESP: the request cycle
    // itself when there are no wait states, else the last WAIT cycle.
    lookup = (in_idle && rd_req && (LATENCY == 1)) ||
             ((state_q == S_WAIT) && (cnt_q == LW'(1)));
    lookup_addr = in_idle ? ALUOutM : addr_q;
    lookup_idx  = lookup_addr[AW-1:0];
    lookup_oor  = |lookup_addr[SIZE-1:AW];

    // The RAM port is free whenever no lookup and no accepted write happens;
    // an accepted out-of-range write also blocks the drain.
    drain = !lookup && !wr_acc && (count_q != '0);

    StallM = (in_idle && MemReqM && (!MemWriteM || wb_full)) ||
             (state_q == S_WAIT);
  end

  always_comb begin
    ram_rdata = ram[lookup_idx];
  end

  // Scan from oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_pos  = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      fwd_pos = PW'((int'(head_q) + i) % WB_DEPTH);
      if ((i < int'(count_q)) && (wb_idx_q[fwd_pos] == lookup_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_q[fwd_pos];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    read_data_d = read_data_q;
    addr_err_d  = (lookup && lookup_oor) || (wr_acc && wr_oor);

    case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          addr_d = ALUOutM;
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LW'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == LW'(1)) state_d = S_RESP;
        else                 cnt_d   = cnt_q - 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (lookup) begin
      if (lookup_oor)   read_data_d = '0;
      else if (fwd_hit) read_data_d = fwd_data;
      else              read_data_d = ram_rdata;
    end
  end

  always_comb begin
    wb_idx_d  = wb_idx_q;
    wb_data_d = wb_data_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (enq) begin
      wb_idx_d[tail_q]  = ALUOutM[AW-1:0];
      wb_data_d[tail_q] = WriteDataM;
      tail_d            = ptr_inc(tail_q);
      count_d           = count_q + 1'b1;
    end else if (drain) begin
      head_d  = ptr_inc(head_q);
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      read_data_q <= '0;
      addr_err_q  <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      read_data_q <= read_data_d;
      addr_err_q  <= addr_err_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  // Entry storage is only meaningful below count_q, so it needs no reset.
  always_ff @(posedge CLK) begin
    wb_idx_q  <= wb_idx_d;
    wb_data_q <= wb_data_d;
  end

  // A reset cycle discards the buffer, so it must not commit the head.
  always_ff @(posedge CLK) begin
    if (drain && !Reset) ram[wb_idx_q[head_q]] <= wb_data_q[head_q];
  end

  assign ReadDataM = read_data_q;
  assign RdValidM  = (state_q == S_RESP);
  assign AddrErrM  = addr_err_q;
  assign WbCount   = count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder. The reference model is a RAM image plus a queue
// of pending posted writes; reads return the youngest pending write to the
// word, else the RAM image, and out-of-range reads return zero.

module tb_dmem_responder;

  localparam int SIZE     = 48;
  localparam int DEPTH    = 256;
  localparam int LATENCY  = 2;
  localparam int WB_DEPTH = 4;
  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = $clog2(WB_DEPTH + 1);

  logic            CLK;
  logic            Reset;
  logic            MemReqM;
  logic            MemWriteM;
  logic [SIZE-1:0] ALUOutM;
  logic [SIZE-1:0] WriteDataM;
  logic [SIZE-1:0] ReadDataM;
  logic            StallM;
  logic            RdValidM;
  logic            AddrErrM;
  logic [CW-1:0]   WbCount;
  logic [1:0]      dbg_state;

  dmem_responder #(
    .SIZE(SIZE), .DEPTH(DEPTH), .LATENCY(LATENCY), .WB_DEPTH(WB_DEPTH)
  ) dut (
    .CLK(CLK), .Reset(Reset), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
    .StallM(StallM), .RdValidM(RdValidM), .AddrErrM(AddrErrM),
    .WbCount(WbCount), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic [AW-1:0]   idx;
    logic [SIZE-1:0] data;
  } wb_entry_t;

  wb_entry_t       m_wb[$];
  logic [SIZE-1:0] m_ram [DEPTH];
  bit              m_known [DEPTH];
  logic [SIZE-1:0] exp_q[$];
  logic [SIZE-1:0] exp_rdata;
  bit              exp_err;
  int              n_checks = 0;
  int              n_fail   = 0;

  function automatic logic [SIZE-1:0] rnd_data();
    return SIZE'({$urandom, $urandom});
  endfunction

  function automatic logic [SIZE-1:0] model_read(input logic [SIZE-1:0] addr);
    logic [AW-1:0] idx;
    idx = addr[AW-1:0];
    if (addr[SIZE-1:AW] != 0) return '0;
    for (int i = m_wb.size() - 1; i >= 0; i--)
      if (m_wb[i].idx == idx) return m_wb[i].data;
    return m_ram[idx];
  endfunction

  function automatic bit model_readable(input logic [SIZE-1:0] addr);
    if (addr[SIZE-1:AW] != 0) return 1'b1;
    if (m_known[addr[AW-1:0]]) return 1'b1;
    foreach (m_wb[i]) if (m_wb[i].idx == addr[AW-1:0]) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the model by one clock: a lookup samples memory, an accepted
  // write is posted, and any other cycle retires the oldest posted write.
  task automatic model_step(input bit lookup, input bit accept,
                            input logic [SIZE-1:0] addr, input logic [SIZE-1:0] data);
    bit        oor;
    bit        err_n;
    wb_entry_t e;
    oor   = (addr[SIZE-1:AW] != 0);
    err_n = 1'b0;
    if (lookup) begin
      exp_rdata = model_read(addr);
      exp_q.push_back(exp_rdata);
      err_n = oor;
    end
    if (accept) begin
      err_n = oor;
      if (!oor) begin
        e.idx  = addr[AW-1:0];
        e.data = data;
        m_wb.push_back(e);
      end
    end else if (!lookup && m_wb.size() != 0) begin
      e = m_wb.pop_front();
      m_ram[e.idx]   = e.data;
      m_known[e.idx] = 1'b1;
    end
    exp_err = err_n;
  endtask

  task automatic model_reset();
    m_wb.delete();
    exp_q.delete();
    exp_rdata = '0;
    exp_err   = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // Entered at posedge+1; drives one cycle, checks outputs at posedge+2,
  // returns at the following posedge+1.
  task automatic drive_cycle(input bit req, input bit we,
                             input logic [SIZE-1:0] addr, input logic [SIZE-1:0] data,
                             input bit lookup, input bit accept,
                             input bit stall_e, input bit valid_e, input string tag,
                             output logic [SIZE-1:0] rd_seen, output logic err_seen);
    MemReqM    = req;
    MemWriteM  = we;
    ALUOutM    = addr;
    WriteDataM = data;
    #1;
    n_checks++;
    if (StallM !== stall_e) begin
      n_fail++;
      $display("FAIL %s stall: got %0b expected %0b at %0t", tag, StallM, stall_e, $time);
    end
    n_checks++;
    if (RdValidM !== valid_e) begin
      n_fail++;
      $display("FAIL %s rd_valid: got %0b expected %0b at %0t", tag, RdValidM, valid_e, $time);
    end
    n_checks++;
    if (AddrErrM !== exp_err) begin
      n_fail++;
      $display("FAIL %s addr_err: got %0b expected %0b at %0t", tag, AddrErrM, exp_err, $time);
    end
    n_checks++;
    if (WbCount !== CW'(m_wb.size())) begin
      n_fail++;
      $display("FAIL %s wb_count: got %0d expected %0d at %0t", tag, WbCount, m_wb.size(), $time);
    end
    n_checks++;
    if (ReadDataM !== exp_rdata) begin
      n_fail++;
      $display("FAIL %s read_data: got %0h expected %0h at %0t", tag, ReadDataM, exp_rdata, $time);
    end
    rd_seen  = ReadDataM;
    err_seen = AddrErrM;
    model_step(lookup, accept, addr, data);
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_idle(input int n, output logic err_first);
    logic [SIZE-1:0] rd;
    logic            er;
    err_first = 1'b0;
    for (int k = 0; k < n; k++) begin
      drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, "idle", rd, er);
      if (k == 0) err_first = er;
    end
  endtask

  task automatic drive_read(input logic [SIZE-1:0] addr,
                            output logic [SIZE-1:0] got, output logic err_resp);
    logic [SIZE-1:0] rd;
    logic [SIZE-1:0] exp;
    logic            er;
    got      = '0;
    err_resp = 1'b0;
    for (int k = 0; k <= LATENCY; k++) begin
      drive_cycle(1'b1, 1'b0, addr, rnd_data(), (k == LATENCY - 1), 1'b0,
                  (k < LATENCY), (k == LATENCY), "read", rd, er);
      if (k == LATENCY) begin
        got      = rd;
        err_resp = er;
      end
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL scoreboard read %0h: got %0h expected %0h", addr, got, exp);
    end
  endtask

  task automatic drive_write(input logic [SIZE-1:0] addr, input logic [SIZE-1:0] data,
                             output int stalls);
    logic [SIZE-1:0] rd;
    logic            er;
    bit              full;
    stalls = 0;
    for (int g = 0; g < 2; g++) begin
      full = (m_wb.size() == WB_DEPTH);
      drive_cycle(1'b1, 1'b1, addr, data, 1'b0, !full, full, 1'b0, "write", rd, er);
      if (!full) break;
      stalls++;
    end
  endtask

  // ---------------- tests ----------------
  logic [SIZE-1:0] got;
  logic            er;
  int              st;

  task automatic test_reset();
    Reset = 1'b1; MemReqM = 1'b0; MemWriteM = 1'b0; ALUOutM = '0; WriteDataM = '0;
    repeat (3) @(posedge CLK);
    #1;
    Reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (StallM !== 1'b0) begin n_fail++; $display("FAIL reset stall: got %0b expected 0", StallM); end
    n_checks++;
    if (RdValidM !== 1'b0) begin n_fail++; $display("FAIL reset rd_valid: got %0b expected 0", RdValidM); end
    n_checks++;
    if (AddrErrM !== 1'b0) begin n_fail++; $display("FAIL reset addr_err: got %0b expected 0", AddrErrM); end
    n_checks++;
    if (WbCount !== '0) begin n_fail++; $display("FAIL reset wb_count: got %0d expected 0", WbCount); end
    n_checks++;
    if (ReadDataM !== '0) begin n_fail++; $display("FAIL reset read_data: got %0h expected 0", ReadDataM); end
    n_checks++;
    if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset dbg_state: got %0d expected 0", dbg_state); end
    model_step(1'b0, 1'b0, '0, '0);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_forwarding();
    drive_idle(WB_DEPTH + 1, er);
    drive_write(48'd5, 48'h0000_0000_00AA, st);
    n_checks++;
    if (WbCount !== CW'(1)) begin n_fail++; $display("FAIL fwd wb_count: got %0d expected 1", WbCount); end
    drive_read(48'd5, got, er);
    n_checks++;
    if (got !== 48'h00AA) begin n_fail++; $display("FAIL fwd data: got %0h expected aa", got); end
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL fwd addr_err: got %0b expected 0", er); end
  endtask

  task automatic test_buffer_full();
    drive_idle(WB_DEPTH + 1, er);
    for (int i = 0; i < 4; i++) begin
      drive_write(SIZE'(i), rnd_data(), st);
      n_checks++;
      if (st != 0) begin n_fail++; $display("FAIL full stall_cycles w%0d: got %0d expected 0", i, st); end
      n_checks++;
      if (WbCount !== CW'(i + 1)) begin n_fail++; $display("FAIL full wb_count w%0d: got %0d expected %0d", i, WbCount, i + 1); end
    end
    drive_write(48'd4, rnd_data(), st);
    n_checks++;
    if (st != 1) begin n_fail++; $display("FAIL full fifth stall_cycles: got %0d expected 1", st); end
    n_checks++;
    if (WbCount !== CW'(4)) begin n_fail++; $display("FAIL full fifth wb_count: got %0d expected 4", WbCount); end
    drive_idle(WB_DEPTH, er);
    n_checks++;
    if (WbCount !== '0) begin n_fail++; $display("FAIL full drained wb_count: got %0d expected 0", WbCount); end
  endtask

  task automatic test_youngest_wins();
    drive_idle(WB_DEPTH + 1, er);
    drive_write(48'd7, 48'h11, st);
    drive_write(48'd7, 48'h22, st);
    drive_read(48'd7, got, er);
    n_checks++;
    if (got !== 48'h22) begin n_fail++; $display("FAIL youngest pair: got %0h expected 22", got); end
    drive_idle(WB_DEPTH + 1, er);
    drive_write(48'd7, 48'h33, st);
    drive_write(48'd7, 48'h44, st);
    drive_write(48'd7, 48'h55, st);
    drive_read(48'd7, got, er);
    n_checks++;
    if (got !== 48'h55) begin n_fail++; $display("FAIL youngest triple: got %0h expected 55", got); end
  endtask

  task automatic test_out_of_range();
    drive_idle(WB_DEPTH + 1, er);
    drive_read(48'h100, got, er);
    n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL oor read data: got %0h expected 0", got); end
    n_checks++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL oor read addr_err: got %0b expected 1", er); end
    drive_write(48'd8, 48'h66, st);
    drive_write(48'h1_0000, 48'h77, st);
    n_checks++;
    if (st != 0) begin n_fail++; $display("FAIL oor write stall_cycles: got %0d expected 0", st); end
    n_checks++;
    if (WbCount !== CW'(1)) begin n_fail++; $display("FAIL oor write wb_count: got %0d expected 1", WbCount); end
    drive_idle(2, er);
    n_checks++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL oor write addr_err: got %0b expected 1", er); end
  endtask

  task automatic test_ram_path();
    drive_idle(WB_DEPTH + 1, er);
    drive_write(48'd9, 48'h5555, st);
    drive_idle(3, er);
    n_checks++;
    if (WbCount !== '0) begin n_fail++; $display("FAIL ram_path wb_count: got %0d expected 0", WbCount); end
    drive_read(48'd9, got, er);
    n_checks++;
    if (got !== 48'h5555) begin n_fail++; $display("FAIL ram_path data: got %0h expected 5555", got); end
  endtask

  task automatic test_back_to_back();
    drive_write(48'd10, 48'hA0A0, st);
    drive_write(48'd11, 48'hB1B1, st);
    drive_read(48'd10, got, er);
    n_checks++;
    if (got !== 48'hA0A0) begin n_fail++; $display("FAIL b2b first: got %0h expected a0a0", got); end
    drive_read(48'd11, got, er);
    n_checks++;
    if (got !== 48'hB1B1) begin n_fail++; $display("FAIL b2b second: got %0h expected b1b1", got); end
  endtask

  task automatic test_reset_during_wait();
    drive_idle(WB_DEPTH + 1, er);
    drive_write(48'd20, rnd_data(), st);
    drive_write(48'd21, rnd_data(), st);
    drive_write(48'd22, rnd_data(), st);
    MemReqM = 1'b1; MemWriteM = 1'b0; ALUOutM = 48'd20;
    #1;
    n_checks++;
    if (StallM !== 1'b1) begin n_fail++; $display("FAIL rst_wait req stall: got %0b expected 1", StallM); end
    model_step(1'b0, 1'b0, 48'd20, '0);
    @(posedge CLK);
    #1;
    Reset = 1'b1;
    #1;
    n_checks++;
    if (WbCount !== CW'(2)) begin n_fail++; $display("FAIL rst_wait wb_count before: got %0d expected 2", WbCount); end
    n_checks++;
    if (StallM !== 1'b1) begin n_fail++; $display("FAIL rst_wait wait stall: got %0b expected 1", StallM); end
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    MemReqM = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (StallM !== 1'b0) begin n_fail++; $display("FAIL rst_wait stall: got %0b expected 0", StallM); end
    n_checks++;
    if (RdValidM !== 1'b0) begin n_fail++; $display("FAIL rst_wait rd_valid: got %0b expected 0", RdValidM); end
    n_checks++;
    if (WbCount !== '0) begin n_fail++; $display("FAIL rst_wait wb_count: got %0d expected 0", WbCount); end
    n_checks++;
    if (ReadDataM !== '0) begin n_fail++; $display("FAIL rst_wait read_data: got %0h expected 0", ReadDataM); end
    model_step(1'b0, 1'b0, '0, '0);
    @(posedge CLK);
    #1;
    // The drained word survives the reset; the discarded ones are not read.
    drive_read(48'd20, got, er);
  endtask

  task automatic test_random();
    logic [SIZE-1:0] a;
    int              op;
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      a  = SIZE'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a[AW + $urandom_range(0, SIZE - AW - 1)] = 1'b1;
      if (op < 4 || (op < 7 && !model_readable(a))) begin
        drive_write(a, rnd_data(), st);
        n_checks++;
        if (st > 1) begin n_fail++; $display("FAIL rand write stall_cycles: got %0d expected <=1", st); end
      end else if (op < 7) begin
        drive_read(a, got, er);
        n_checks++;
        if (er !== (a[SIZE-1:AW] != 0)) begin
          n_fail++;
          $display("FAIL rand read addr_err %0h: got %0b expected %0b", a, er, (a[SIZE-1:AW] != 0));
        end
      end else begin
        drive_idle($urandom_range(1, 3), er);
      end
    end
    drive_idle(WB_DEPTH + 1, er);
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_buffer_full();
    test_youngest_wins();
    test_out_of_range();
    test_ram_path();
    test_back_to_back();
    test_reset_during_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
